amm_trans_engine: RTL and testbench

- Consumer end of the op-packet handshake produced by the test control FSM.
- Accepts one op packet at a time (write or read burst, word address, byte offsets, burstcount) and executes it as an Avalon-MM burst master transaction on the memory under test.
- Generates write data and byte enables, and collects read beats.
- Forwards read beats to the compare block and reports busy to the control FSM for end-of-test detection.

---
 rtl/amm_trans_engine.sv | 163 ++++++++++++++++
 tb/tb_amm_trans_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_trans_engine.sv
// Avalon-MM burst master that executes one op packet at a time: write bursts with generated
// data and byte enables, or read bursts whose beats are forwarded to the compare block.
module amm_trans_engine #(
  parameter  int ADDR_W      = 32,
  parameter  int AMM_DATA_W  = 64,
  parameter  int AMM_BURST_W = 11,
  localparam int ADDR_B_W    = $clog2(AMM_DATA_W / 8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic                      op_type_i,
  input  logic [ADDR_W-1:0]         op_word_addr_i,
  input  logic [AMM_BURST_W-1:0]    op_burstcount_i,
  input  logic [ADDR_B_W-1:0]       op_start_offset_i,
  input  logic [ADDR_B_W-1:0]       op_end_offset_i,
  input  logic [31:0]               data_pattern_i,
  output logic [ADDR_W-1:0]         amm_address_o,
  output logic                      amm_read_o,
  output logic                      amm_write_o,
  output logic [AMM_DATA_W-1:0]     amm_writedata_o,
  output logic [AMM_DATA_W/8-1:0]   amm_byteenable_o,
  output logic [AMM_BURST_W-1:0]    amm_burstcount_o,
  input  logic                      amm_waitrequest_i,
  input  logic                      amm_readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]     amm_readdata_i,
  output logic                      rd_valid_o,
  output logic [AMM_DATA_W-1:0]     rd_data_o,
  output logic                      rd_last_o,
  output logic                      busy_o
);

  localparam int BE_W  = AMM_DATA_W / 8;
  localparam int LANES = AMM_DATA_W / 32;
  localparam logic [AMM_BURST_W-1:0] ONE = AMM_BURST_W'(1);

  typedef enum logic [1:0] {IDLE_S, WRITE_S, READ_CMD_S, READ_WAIT_S} state_t;

  state_t                  state;
  logic [AMM_BURST_W-1:0]  beat_cnt;
  logic [AMM_BURST_W-1:0]  burst_q;
  logic [ADDR_B_W-1:0]     start_q;
  logic [ADDR_B_W-1:0]     end_q;
  logic [31:0]             pattern_q;

  logic [AMM_BURST_W-1:0]  op_burst_eff;
  logic [AMM_BURST_W-1:0]  next_beat;
  logic                    last_beat;
  logic                    next_is_last;

  // Lane k of beat b carries pattern + b*LANES + k, wrapping at 32 bits.
  function automatic logic [AMM_DATA_W-1:0] beat_data(input logic [31:0]            pat,
                                                       input logic [AMM_BURST_W-1:0] beat);
    logic [AMM_DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++)
      d[k*32 +: 32] = pat + 32'(beat) * 32'(LANES) + 32'(k);
    return d;
  endfunction

  function automatic logic [BE_W-1:0] beat_be(input logic                is_first,
                                              input logic                is_last,
                                              input logic [ADDR_B_W-1:0] s_off,
                                              input logic [ADDR_B_W-1:0] e_off);
    logic [BE_W-1:0] be;
    be = '0;
    for (int i = 0; i < BE_W; i++)
      be[i] = (!is_first || i >= int'(s_off)) && (!is_last || i <= int'(e_off));
    return be;
  endfunction

  assign op_burst_eff = (op_burstcount_i == '0) ? ONE : op_burstcount_i;
  assign next_beat    = beat_cnt + ONE;
  assign last_beat    = (beat_cnt == burst_q - ONE);
  assign next_is_last = (next_beat == burst_q - ONE);

  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE_S;
      beat_cnt         <= '0;
      burst_q          <= '0;
      start_q          <= '0;
      end_q            <= '0;
      pattern_q        <= '0;
      op_ready_o       <= 1'b1;
      busy_o           <= 1'b0;
      amm_address_o    <= '0;
      amm_read_o       <= 1'b0;
      amm_write_o      <= 1'b0;
      amm_writedata_o  <= '0;
      amm_byteenable_o <= '0;
      amm_burstcount_o <= '0;
      rd_valid_o       <= 1'b0;
      rd_data_o        <= '0;
      rd_last_o        <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      case (state)
        IDLE_S: begin
          if (op_valid_i && op_ready_o) begin
            burst_q          <= op_burst_eff;
            start_q          <= op_start_offset_i;
            end_q            <= op_end_offset_i;
            pattern_q        <= data_pattern_i;
            beat_cnt         <= '0;
            amm_address_o    <= op_word_addr_i;
            amm_burstcount_o <= op_burst_eff;
            amm_byteenable_o <= beat_be(1'b1, op_burst_eff == ONE,
                                        op_start_offset_i, op_end_offset_i);
            op_ready_o       <= 1'b0;
            busy_o           <= 1'b1;
            if (op_type_i) begin
              state      <= READ_CMD_S;
              amm_read_o <= 1'b1;
            end else begin
              state           <= WRITE_S;
              amm_write_o     <= 1'b1;
              amm_writedata_o <= beat_data(data_pattern_i, '0);
            end
          end
        end
        WRITE_S: begin
          if (!amm_waitrequest_i) begin
            if (last_beat) begin
              state       <= IDLE_S;
              amm_write_o <= 1'b0;
              op_ready_o  <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              beat_cnt         <= next_beat;
              amm_writedata_o  <= beat_data(pattern_q, next_beat);
              amm_byteenable_o <= beat_be(1'b0, next_is_last, start_q, end_q);
            end
          end
        end
        READ_CMD_S: begin
          if (!amm_waitrequest_i) begin
            state      <= READ_WAIT_S;
            amm_read_o <= 1'b0;
          end
        end
        READ_WAIT_S: begin
          if (amm_readdatavalid_i) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= amm_readdata_i;
            if (last_beat) begin
              rd_last_o  <= 1'b1;
              state      <= IDLE_S;
              op_ready_o <= 1'b1;
              busy_o     <= 1'b0;
            end else begin
              beat_cnt <= next_beat;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_trans_engine.sv
// Scoreboard bench for amm_trans_engine: a slave model injects stalls and read beats, monitors
// compare every write beat, read command and forwarded read beat against queued expectations.
module tb_amm_trans_engine;

  localparam int ADDR_W = 32;
  localparam int DW     = 64;
  localparam int BW     = 11;
  localparam int BEW    = DW / 8;
  localparam int ABW    = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              op_valid_i, op_ready_o, op_type_i;
  logic [ADDR_W-1:0] op_word_addr_i;
  logic [BW-1:0]     op_burstcount_i;
  logic [ABW-1:0]    op_start_offset_i, op_end_offset_i;
  logic [31:0]       data_pattern_i;
  logic [ADDR_W-1:0] amm_address_o;
  logic              amm_read_o, amm_write_o;
  logic [DW-1:0]     amm_writedata_o;
  logic [BEW-1:0]    amm_byteenable_o;
  logic [BW-1:0]     amm_burstcount_o;
  logic              amm_waitrequest_i, amm_readdatavalid_i;
  logic [DW-1:0]     amm_readdata_i;
  logic              rd_valid_o, rd_last_o, busy_o;
  logic [DW-1:0]     rd_data_o;

  amm_trans_engine #(.ADDR_W(ADDR_W), .AMM_DATA_W(DW), .AMM_BURST_W(BW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_type_i(op_type_i),
    .op_word_addr_i(op_word_addr_i), .op_burstcount_i(op_burstcount_i),
    .op_start_offset_i(op_start_offset_i), .op_end_offset_i(op_end_offset_i),
    .data_pattern_i(data_pattern_i),
    .amm_address_o(amm_address_o), .amm_read_o(amm_read_o), .amm_write_o(amm_write_o),
    .amm_writedata_o(amm_writedata_o), .amm_byteenable_o(amm_byteenable_o),
    .amm_burstcount_o(amm_burstcount_o), .amm_waitrequest_i(amm_waitrequest_i),
    .amm_readdatavalid_i(amm_readdatavalid_i), .amm_readdata_i(amm_readdata_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [BW-1:0] bc; logic [DW-1:0] data; logic [BEW-1:0] be; } wr_exp_t;
  typedef struct { logic [31:0] addr; logic [BW-1:0] bc; logic [BEW-1:0] be; } cmd_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } rd_exp_t;

  wr_exp_t  wr_q[$];
  cmd_exp_t cmd_q[$];
  rd_exp_t  rd_q[$];

  int err_cnt = 0;
  int chk_cnt = 0;

  int cyc = 0, wr_done_cyc = 0, rd_start_cyc = 0;
  int rd_hi_cnt = 0, rd_pulse_cnt = 0, rd_last_cnt = 0;
  int wr_stall_beat = 0, wr_stall_cfg = 0, rd_stall_cfg = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [31:0] pat, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = pat + 32'(b * (DW / 32) + k);
    return d;
  endfunction

  function automatic logic [BEW-1:0] exp_be(input int b, input int bc, input int s, input int e);
    logic [BEW-1:0] m;
    m = 8'hFF;
    if (b == 0)      m = m & (8'hFF << s);
    if (b == bc - 1) m = m & (8'hFF >> (7 - e));
    return m;
  endfunction

  // Slave model: drives waitrequest and read beats; read expectations are queued as driven.
  initial begin : slave
    int wr_beat, wr_stall_left, rd_stall_left, rd_pending, gap;
    rd_exp_t r;
    wr_beat = 0; wr_stall_left = 0; rd_stall_left = 0; rd_pending = 0; gap = 0;
    amm_waitrequest_i = 1'b1; amm_readdatavalid_i = 1'b0; amm_readdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      amm_readdatavalid_i = 1'b0;
      amm_readdata_i      = {$urandom, $urandom};
      if (rst_i) begin
        amm_waitrequest_i = 1'b1;
        rd_pending = 0; wr_beat = 0; wr_stall_left = wr_stall_cfg;
      end else if (amm_write_o) begin
        if (wr_beat == wr_stall_beat && wr_stall_left > 0) begin
          amm_waitrequest_i = 1'b1; wr_stall_left--;
        end else begin
          amm_waitrequest_i = 1'b0; wr_beat++;
        end
      end else if (amm_read_o) begin
        if (rd_stall_left > 0) begin
          amm_waitrequest_i = 1'b1; rd_stall_left--;
        end else begin
          amm_waitrequest_i = 1'b0;
          rd_pending = int'(amm_burstcount_o);
          gap = $urandom_range(0, 5);
        end
      end else begin
        amm_waitrequest_i = 1'b1;
        wr_beat = 0; wr_stall_left = wr_stall_cfg; rd_stall_left = rd_stall_cfg;
        if (rd_pending > 0) begin
          if (gap > 0) gap--;
          else begin
            amm_readdatavalid_i = 1'b1;
            r.data = amm_readdata_i;
            r.last = (rd_pending == 1);
            rd_q.push_back(r);
            rd_pending--;
            gap = $urandom_range(0, 5);
          end
        end
      end
    end
  end

  initial begin : monitor
    logic rdv_d, rd_prev;
    rdv_d = 1'b0; rd_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (amm_write_o) begin
        if (wr_q.size() == 0) check("wr_unexpected", amm_write_o, 1'b0);
        else begin
          check("wr_addr", amm_address_o, wr_q[0].addr);
          check("wr_bc", amm_burstcount_o, wr_q[0].bc);
          if (!amm_waitrequest_i) begin
            check("wr_data", amm_writedata_o, wr_q[0].data);
            check("wr_be", amm_byteenable_o, wr_q[0].be);
            void'(wr_q.pop_front());
            wr_done_cyc = cyc;
          end
        end
      end
      if (amm_read_o) begin
        rd_hi_cnt++;
        if (!rd_prev) rd_start_cyc = cyc;
        if (cmd_q.size() == 0) check("rd_cmd_unexpected", amm_read_o, 1'b0);
        else begin
          check("rd_cmd_addr", amm_address_o, cmd_q[0].addr);
          check("rd_cmd_bc", amm_burstcount_o, cmd_q[0].bc);
          check("rd_cmd_be", amm_byteenable_o, cmd_q[0].be);
          if (!amm_waitrequest_i) void'(cmd_q.pop_front());
        end
      end
      if (rd_valid_o || rdv_d) check("rd_latency", rd_valid_o, rdv_d);
      if (rd_valid_o) begin
        rd_pulse_cnt++;
        if (rd_q.size() == 0) check("rd_unexpected", rd_valid_o, 1'b0);
        else begin
          check("rd_data", rd_data_o, rd_q[0].data);
          check("rd_last", rd_last_o, rd_q[0].last);
          void'(rd_q.pop_front());
        end
      end else if (rd_last_o) check("rd_last_alone", rd_last_o, 1'b0);
      if (rd_last_o) rd_last_cnt++;
      rdv_d   = amm_readdatavalid_i;
      rd_prev = amm_read_o;
    end
  end

  task automatic set_stalls(input int wb, input int wc, input int rc);
    wr_stall_beat = wb; wr_stall_cfg = wc; rd_stall_cfg = rc;
    @(negedge clk_i);
  endtask

  task automatic send_op(input logic rd, input logic [31:0] addr, input logic [BW-1:0] bc,
                         input logic [ABW-1:0] s, input logic [ABW-1:0] e,
                         input logic [31:0] pat, input logic hold);
    int n;
    int bce;
    cmd_exp_t c;
    wr_exp_t  w;
    n = 0;
    op_valid_i = 1'b1; op_type_i = rd; op_word_addr_i = addr; op_burstcount_i = bc;
    op_start_offset_i = s; op_end_offset_i = e; data_pattern_i = pat;
    while (!op_ready_o && n < 200) begin @(negedge clk_i); n++; end
    check("op_accept_timeout", op_ready_o, 1'b1);
    bce = (bc == 0) ? 1 : int'(bc);
    if (rd) begin
      c.addr = addr; c.bc = BW'(bce); c.be = exp_be(0, bce, int'(s), int'(e));
      cmd_q.push_back(c);
    end else begin
      for (int b = 0; b < bce; b++) begin
        w.addr = addr; w.bc = BW'(bce); w.data = exp_data(pat, b);
        w.be = exp_be(b, bce, int'(s), int'(e));
        wr_q.push_back(w);
      end
    end
    @(posedge clk_i); #1;
    if (!hold) op_valid_i = 1'b0;
    @(negedge clk_i);
    check("cmd_latency", rd ? amm_read_o : amm_write_o, 1'b1);
    check("busy_on", busy_o, 1'b1);
    check("ready_off", op_ready_o, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!op_ready_o && n < 300) begin @(negedge clk_i); n++; end
    check("idle_timeout", op_ready_o, 1'b1);
  endtask

  initial begin : main
    int n;
    op_valid_i = 1'b0; op_type_i = 1'b0; op_word_addr_i = '0; op_burstcount_i = '0;
    op_start_offset_i = '0; op_end_offset_i = '0; data_pattern_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", op_ready_o, 1'b1);
    check("rst_write", amm_write_o, 1'b0);
    check("rst_read", amm_read_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rd_valid", rd_valid_o, 1'b0);
    check("rst_rd_last", rd_last_o, 1'b0);
    check("rst_addr", amm_address_o, '0);
    check("rst_be", amm_byteenable_o, '0);
    check("rst_bc", amm_burstcount_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single-beat write: byteenable 0x3C, data {0x11,0x10}
    set_stalls(0, 0, 0);
    send_op(1'b0, 32'h100, 11'd1, 3'd2, 3'd5, 32'h10, 1'b0);
    wait_idle(n);
    check("t1_cycles", n, 1);
    check("t1_write_off", amm_write_o, 1'b0);

    // Four-beat write with a two-cycle stall on the second beat
    set_stalls(1, 2, 0);
    send_op(1'b0, 32'h200, 11'd4, 3'd3, 3'd4, 32'h1000, 1'b0);
    wait_idle(n);
    check("t2_cycles", n, 6);
    check("t2_busy_off", busy_o, 1'b0);
    check("t2_wr_q_empty", wr_q.size(), 0);

    // Four-beat read with a three-cycle command stall and random data gaps
    set_stalls(0, 0, 3);
    rd_hi_cnt = 0; rd_pulse_cnt = 0; rd_last_cnt = 0;
    send_op(1'b1, 32'h2000, 11'd4, 3'd0, 3'd7, 32'h0, 1'b0);
    wait_idle(n);
    @(negedge clk_i);
    check("t3_read_high", rd_hi_cnt, 4);
    check("t3_pulses", rd_pulse_cnt, 4);
    check("t3_last_cnt", rd_last_cnt, 1);
    check("t3_rd_q_empty", rd_q.size(), 0);
    check("t3_busy_off", busy_o, 1'b0);

    // Back-to-back: two-beat write then one-beat read with op_valid held
    set_stalls(0, 0, 0);
    send_op(1'b0, 32'h300, 11'd2, 3'd1, 3'd6, 32'h55, 1'b1);
    send_op(1'b1, 32'h3000, 11'd1, 3'd2, 3'd2, 32'h0, 1'b0);
    wait_idle(n);
    @(negedge clk_i);
    check("t4_idle_gap", rd_start_cyc - wr_done_cyc, 2);
    check("t4_queues_empty", wr_q.size() + cmd_q.size() + rd_q.size(), 0);

    // Reset during beat 2 of an 8-beat write, then a normal write
    send_op(1'b0, 32'h4000, 11'd8, 3'd0, 3'd7, 32'hA000_0000, 1'b0);
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("t5_write_async_off", amm_write_o, 1'b0);
    check("t5_ready", op_ready_o, 1'b1);
    check("t5_busy", busy_o, 1'b0);
    wr_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    set_stalls(0, 0, 0);
    send_op(1'b0, 32'h4100, 11'd2, 3'd4, 3'd3, 32'h7, 1'b0);
    wait_idle(n);
    check("t5_after_cycles", n, 2);
    check("t5_wr_q_empty", wr_q.size(), 0);

    // Burstcount 0 read behaves as a single beat
    rd_pulse_cnt = 0; rd_last_cnt = 0;
    send_op(1'b1, 32'h5000, 11'd0, 3'd0, 3'd7, 32'h0, 1'b0);
    wait_idle(n);
    @(negedge clk_i);
    check("t6_pulses", rd_pulse_cnt, 1);
    check("t6_last_cnt", rd_last_cnt, 1);
    check("t6_rd_q_empty", rd_q.size(), 0);

    // Single beat with start > end: byteenable all zeros; lane data wraps at 32 bits
    send_op(1'b0, 32'h600, 11'd1, 3'd5, 3'd2, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    check("t7_cycles", n, 1);
    @(negedge clk_i);
    check("t7_wr_q_empty", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
